// File: rtl/jtexterm_irq_pkg.sv
// Shared constants for the sound-CPU interrupt controller: register map,
// CTRL bit positions and the IM2 vector helper.
package jtexterm_irq_pkg;

   typedef enum logic [1:0] {
      REG_MASK = 2'd0,
      REG_PEND = 2'd1,
      REG_STAT = 2'd2,
      REG_CTRL = 2'd3
   } reg_addr_e;

   localparam int         CTRL_EN      = 0;
   localparam int         CTRL_AUTOCLR = 1;
   localparam logic [7:0] VEC_SPURIOUS = 8'h0E;
   localparam logic [2:0] IDX_NONE     = 3'd7;

   // Vector for an acknowledge: base | (index<<1), or the spurious slot.
   function automatic logic [7:0] irq_vector(input logic [7:0] base,
                                             input logic       valid,
                                             input logic [2:0] idx);
      return valid ? (base | {4'b0000, idx, 1'b0}) : (base | VEC_SPURIOUS);
   endfunction

endpackage

// File: rtl/jtexterm_irq_prio.sv
// Fixed-priority encoder: the lowest-indexed asserted request wins.
module jtexterm_irq_prio
   import jtexterm_irq_pkg::*;
#(
   parameter int NSRC = 4
)(
   input  logic [NSRC-1:0] i_req,
   output logic [2:0]      o_index,
   output logic            o_valid
);

   always_comb begin
      o_valid = 1'b0;
      o_index = IDX_NONE;
      // Scan downwards so the lowest index is the last one written.
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_valid = 1'b1;
            o_index = 3'(i);
         end
      end
   end

endmodule

// File: rtl/jtexterm_irqctl.sv
// Z80 IM2 interrupt controller: edge/level sources, mask, pending latch,
// priority acknowledge with vector output and a small CPU register window.
module jtexterm_irqctl
   import jtexterm_irq_pkg::*;
#(
   parameter int              NSRC    = 4,
   parameter logic [NSRC-1:0] EDGE    = '1,
   parameter logic [7:0]      VECBASE = 8'hE0
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NSRC-1:0] src,
   input  logic            cs,
   input  logic [1:0]      addr,
   input  logic            wr_n,
   input  logic [7:0]      din,
   output logic [7:0]      dout,
   input  logic            iack,
   output logic            int_n,
   output logic [7:0]      vector
);

   logic [NSRC-1:0] r_mask;
   logic [NSRC-1:0] r_pend;
   logic [NSRC-1:0] r_src_d;
   logic [1:0]      r_ctrl;
   logic            r_armed;
   logic            r_iack_d;
   logic [2:0]      r_stat_idx;
   logic [7:0]      r_vector;
   logic [7:0]      r_dout;
   logic            r_int_n;

   logic            w_wr;
   logic            w_ack;
   logic            w_valid;
   logic [2:0]      w_idx;
   logic [2:0]      w_stat_nxt;
   logic [NSRC-1:0] w_masked;
   logic [NSRC-1:0] w_set;
   logic [NSRC-1:0] w_clr;
   logic [NSRC-1:0] w_pend_nxt;
   logic [7:0]      w_rd;
   logic            w_unused;

   assign w_wr     = cs & ~wr_n;
   assign w_masked = r_pend & r_mask;
   // r_armed is low for the first clock after reset so that lines already
   // high at release are taken as history, not as fresh edges or acks.
   assign w_ack    = iack & ~r_iack_d & r_armed;
   assign w_set    = src & ~r_src_d & {NSRC{r_armed}};
   assign w_unused = ^din;

   jtexterm_irq_prio #(.NSRC(NSRC)) u_prio (
      .i_req   (w_masked),
      .o_index (w_idx),
      .o_valid (w_valid)
   );

   always_comb begin
      w_clr = '0;
      if (w_wr && addr == REG_PEND)
         w_clr = din[NSRC-1:0];
      if (w_ack && w_valid && r_ctrl[CTRL_AUTOCLR])
         w_clr = w_clr | (NSRC'(1) << w_idx);
   end

   // Edge bits: a simultaneous set beats any clear. Level bits track src.
   always_comb begin
      w_pend_nxt = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (EDGE[i])
            w_pend_nxt[i] = w_set[i] | (r_pend[i] & ~w_clr[i]);
         else
            w_pend_nxt[i] = src[i];
      end
   end

   assign w_stat_nxt = w_ack ? (w_valid ? w_idx : IDX_NONE) : r_stat_idx;

   // STAT reads the index being latched this cycle, so a read issued
   // together with the acknowledge already reports the new winner.
   always_comb begin
      w_rd = 8'h00;
      case (reg_addr_e'(addr))
         REG_MASK: w_rd = 8'(r_mask);
         REG_PEND: w_rd = 8'(r_pend);
         REG_STAT: w_rd = {|w_masked, 4'b0000, w_stat_nxt};
         REG_CTRL: w_rd = {6'b000000, r_ctrl};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask     <= '0;
         r_pend     <= '0;
         r_src_d    <= '0;
         r_ctrl     <= 2'b00;
         r_armed    <= 1'b0;
         r_iack_d   <= 1'b0;
         r_stat_idx <= IDX_NONE;
         r_vector   <= VECBASE | VEC_SPURIOUS;
         r_dout     <= 8'hFF;
         r_int_n    <= 1'b1;
      end else begin
         r_armed  <= 1'b1;
         r_src_d  <= src;
         r_iack_d <= iack;
         r_pend   <= w_pend_nxt;
         r_int_n  <= ~(r_ctrl[CTRL_EN] & (|w_masked));
         r_dout   <= cs ? w_rd : 8'hFF;
         if (w_wr && addr == REG_MASK)
            r_mask <= din[NSRC-1:0];
         if (w_wr && addr == REG_CTRL)
            r_ctrl <= din[1:0];
         if (w_ack) begin
            r_stat_idx <= w_stat_nxt;
            r_vector   <= irq_vector(VECBASE, w_valid, w_idx);
         end
      end
   end

   assign dout   = r_dout;
   assign int_n  = r_int_n;
   assign vector = r_vector;

endmodule

// File: doc/jtexterm_irqctl.md
JTEXTERM_IRQCTL -- requirements
Module: jtexterm_irqctl

Interface
REQ-001 SHALL have parameter NSRC, default 4: number of interrupt sources, legal range 1..7.
REQ-002 SHALL have parameter EDGE, default all ones, NSRC bits: per-source mode, 1 = rising-edge latched, 0 = level.
REQ-003 SHALL have parameter VECBASE, default 8'hE0: IM2 vector base; bits [3:0] SHALL be zero.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 src  in  NSRC  interrupt request lines, active high, synchronous to clk.
REQ-007 cs  in  1  register-window select from the sound-CPU decoder.
REQ-008 addr  in  2  register index.
REQ-009 wr_n  in  1  CPU write strobe, active low.
REQ-010 din  in  8  CPU write data.
REQ-011 dout  out  8  registered read data.
REQ-012 iack  in  1  interrupt acknowledge, active high (iorq_n low, optionally qualified with m1_n).
REQ-013 int_n  out  1  to CPU INT pin, active low.
REQ-014 vector  out  8  IM2 vector presented during acknowledge.

Function
REQ-015 Register map: 0 MASK (R/W, bit i enables source i); 1 PEND (read returns pending bits; writing 1 clears edge-mode bits); 2 STAT (read only: bit7 = any masked pending, bits[2:0] = last acknowledged index); 3 CTRL (bit0 global enable, bit1 auto-clear on ack).
REQ-016 A write SHALL occur on every clk cycle with cs=1 and wr_n=0; repeated writes SHALL be idempotent.
REQ-017 dout SHALL present the register at addr one clk after addr/cs are sampled; unused bits SHALL read 0; with cs=0, dout SHALL be 8'hFF.
REQ-018 Edge-mode source: a 0->1 transition of src[i] between consecutive clk samples SHALL set pend[i] on the next edge.
REQ-019 Level-mode source: pend[i] SHALL equal src[i] registered one clk; PEND writes and auto-clear SHALL NOT affect it.
REQ-020 A set and a clear of the same edge-mode bit in the same cycle: set SHALL win.
REQ-021 int_n SHALL be 0 exactly when CTRL.bit0=1 and (pend & MASK) != 0, registered; latency from src edge to int_n low is 2 clk.
REQ-022 Priority: lowest-indexed masked pending source SHALL win.
REQ-023 On the rising edge of iack, the winning index SHALL be latched into STAT[2:0], and vector SHALL become VECBASE | (index<<1); vector SHALL then hold until the next iack rising edge.
REQ-024 If no masked source is pending at the iack rising edge, vector SHALL be VECBASE | 8'h0E (spurious) and STAT[2:0] SHALL be 7.
REQ-025 With CTRL.bit1=1, the acknowledged edge-mode pending bit SHALL clear in the same cycle that the vector is latched; an edge on that source in the same cycle SHALL keep it set (REQ-020).
REQ-026 iack held high for multiple cycles SHALL count as one acknowledge.
REQ-027 Masking SHALL NOT discard pending bits; unmasking a pending source SHALL assert int_n after 1 clk.

Reset
REQ-028 While rst_n=0: MASK=0, PEND=0, CTRL=0, STAT[2:0]=7, edge-history registers=0, int_n=1, vector=VECBASE|8'h0E, dout=8'hFF.
REQ-029 Reset asserted mid-acknowledge SHALL return all state to REQ-028 values; the first clk after release SHALL NOT generate an edge from a src line that is already high.

Structure
REQ-030 Register indexes, the CTRL bit positions and the spurious vector offset SHALL be constants in a shared package, jtexterm_irq_pkg.
REQ-031 Priority encoding SHALL be a sub-module jtexterm_irq_prio: parametrised on NSRC, combinational, with outputs index and valid.

Verification
REQ-032 Reset release with src=4'b0001: int_n stays 1, PEND reads 0.
REQ-033 MASK=0x0F, CTRL=0x03, pulse src[2] -> int_n low 2 clk later; iack -> vector=0xE4, STAT=0x82, int_n high next cycle.
REQ-034 src[1] and src[3] pending together -> first iack vector=0xE2, second iack vector=0xE6.
REQ-035 Pending edge bit and CTRL.bit1=1, src[0] rises in the same cycle as iack -> pend[0] stays 1 and int_n stays low.
REQ-036 EDGE=4'b1110, src[0] high, write PEND=0x01 -> PEND[0] still reads 1; src[0] low -> PEND[0]=0 after 1 clk.
REQ-037 CTRL.bit0=1, MASK=0, iack -> vector=0xEE, STAT[2:0]=7, int_n=1.
